// File: rtl/stim_seq_pkg.sv
// Shared definitions for the stimulus vector sequencer.
// Contents: FSM state encoding, default table geometry, and the field
// layout of a stimulus word as consumed by the block-level DUT.
package stim_seq_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RUN    = 2'd1,
    FINISH = 2'd2
  } state_t;

  localparam int VEC_W_DEF = 12;
  localparam int DEPTH_DEF = 32;

  // Stimulus word field positions.
  localparam int FLD_R_BUTTON = 0;
  localparam int FLD_G_BUTTON = 1;
  localparam int FLD_KEY      = 2;
  localparam int FLD_START    = 3;
  localparam int FLD_TEST     = 4;
  localparam int FLD_RTS      = 5;
  localparam int FLD_RTR      = 6;
  localparam int FLD_V_IN_LO  = 7;
  localparam int FLD_V_IN_HI  = 10;
  localparam int FLD_OBS      = 11;

endpackage

// File: rtl/stim_sequencer_if.sv
// Control/data bundle between the host (bench control logic) and the
// stimulus sequencer.
//   master : host side - drives table writes, run control, step_ready
//   slave  : sequencer side - drives the stimulus word and status
interface stim_sequencer_if #(
  parameter int VEC_W  = 12,
  parameter int ADDR_W = 5,
  parameter int CNT_W  = 16
);
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [VEC_W-1:0]  wr_data;
  logic              start;
  logic              stop;
  logic              loop_mode;
  logic [ADDR_W:0]   run_len;
  logic              step_ready;
  logic [VEC_W-1:0]  vec_out;
  logic              vec_valid;
  logic [ADDR_W-1:0] step_idx;
  logic              busy;
  logic              done;
  logic              wr_err;
  logic [CNT_W-1:0]  obs_count;

  modport master (
    output wr_en, wr_addr, wr_data, start, stop, loop_mode, run_len, step_ready,
    input  vec_out, vec_valid, step_idx, busy, done, wr_err, obs_count
  );

  modport slave (
    input  wr_en, wr_addr, wr_data, start, stop, loop_mode, run_len, step_ready,
    output vec_out, vec_valid, step_idx, busy, done, wr_err, obs_count
  );
endinterface

// File: rtl/stim_seq_mem.sv
// Stimulus table: DEPTH x VEC_W register array.
// Ports:
//   clock, reset    - system clock, async active-low reset (read register only)
//   i_we/i_waddr/i_wdata - single write port
//   i_rd_en/i_rd_addr    - load read register with table[i_rd_addr]
//   i_rd_clr             - force read register to zero (has priority)
//   o_rd_data            - registered read data
// The array itself is not reset so a table survives a reset pulse.
module stim_seq_mem #(
  parameter int VEC_W  = 12,
  parameter int DEPTH  = 32,
  parameter int ADDR_W = 5
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              i_we,
  input  logic [ADDR_W-1:0] i_waddr,
  input  logic [VEC_W-1:0]  i_wdata,
  input  logic              i_rd_en,
  input  logic              i_rd_clr,
  input  logic [ADDR_W-1:0] i_rd_addr,
  output logic [VEC_W-1:0]  o_rd_data
);

  logic [VEC_W-1:0] r_mem [DEPTH];
  logic [VEC_W-1:0] r_rd_data;

  always_ff @(posedge clock) begin
    if (i_we) r_mem[i_waddr] <= i_wdata;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_rd_data <= '0;
    end else if (i_rd_clr) begin
      r_rd_data <= '0;
    end else if (i_rd_en) begin
      r_rd_data <= r_mem[i_rd_addr];
    end
  end

  assign o_rd_data = r_rd_data;

endmodule

// File: rtl/stim_sequencer.sv
// Stimulus vector sequencer: replays a runtime-loaded table onto the DUT
// input bus, one word per accepted step, with run length, loop mode,
// back-pressure, abort and a saturating count of observation-bit hits.
// Ports:
//   clock - system clock, rising edge
//   reset - asynchronous active-low reset
//   bus   - stim_sequencer_if.slave (table writes, run control, stimulus out)
//
// state  | meaning
// IDLE   | no run; table writable; waiting for start
// RUN    | presenting table[step_idx]; advancing on each accept
// FINISH | one-cycle done pulse after a non-loop run completes
module stim_sequencer
  import stim_seq_pkg::*;
#(
  parameter int VEC_W   = VEC_W_DEF,
  parameter int DEPTH   = DEPTH_DEF,
  parameter int ADDR_W  = $clog2(DEPTH),
  parameter int OBS_BIT = VEC_W - 1,
  parameter int CNT_W   = 16
) (
  input logic             clock,
  input logic             reset,
  stim_sequencer_if.slave bus
);

  localparam logic [ADDR_W:0]   LEN_MAX = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W:0]   LEN_ONE = (ADDR_W+1)'(1);
  localparam logic [ADDR_W-1:0] IDX_ONE = ADDR_W'(1);
  localparam logic [CNT_W-1:0]  CNT_ONE = CNT_W'(1);

  state_t            r_state;
  logic [ADDR_W:0]   r_len;
  logic              r_loop;
  logic [ADDR_W-1:0] r_step_idx;
  logic              r_vec_valid;
  logic              r_busy;
  logic              r_done;
  logic              r_wr_err;
  logic [CNT_W-1:0]  r_obs_count;

  logic              w_start;
  logic [ADDR_W:0]   w_len_clamped;
  logic              w_accept;
  logic              w_last;
  logic [ADDR_W-1:0] w_next_idx;
  logic              w_mem_we;
  logic              w_rd_en;
  logic              w_rd_clr;
  logic [ADDR_W-1:0] w_rd_addr;
  logic [VEC_W-1:0]  w_rd_data;

  // stop beats start in IDLE
  assign w_start       = bus.start & ~bus.stop;
  assign w_len_clamped = (bus.run_len > LEN_MAX) ? LEN_MAX : bus.run_len;
  assign w_accept      = r_vec_valid & bus.step_ready;
  // r_len is never 0 while in RUN, so len-1 cannot underflow here
  assign w_last        = ({1'b0, r_step_idx} == (r_len - LEN_ONE));
  assign w_next_idx    = w_last ? '0 : (r_step_idx + IDX_ONE);
  assign w_mem_we      = bus.wr_en & (r_state != RUN);

  // The memory read register is the vec_out register, so the next word is
  // fetched on the same edge that advances step_idx.
  always_comb begin
    w_rd_en   = 1'b0;
    w_rd_clr  = 1'b0;
    w_rd_addr = '0;
    unique case (r_state)
      IDLE: begin
        if (w_start && (bus.run_len != '0)) w_rd_en  = 1'b1;
        else                                w_rd_clr = 1'b1;
      end
      RUN: begin
        if (bus.stop) begin
          w_rd_clr = 1'b1;
        end else if (w_accept) begin
          if (w_last && !r_loop) begin
            w_rd_clr = 1'b1;
          end else begin
            w_rd_en   = 1'b1;
            w_rd_addr = w_next_idx;
          end
        end
      end
      default: w_rd_clr = 1'b1;
    endcase
  end

  stim_seq_mem #(
    .VEC_W (VEC_W),
    .DEPTH (DEPTH),
    .ADDR_W(ADDR_W)
  ) u_mem (
    .clock    (clock),
    .reset    (reset),
    .i_we     (w_mem_we),
    .i_waddr  (bus.wr_addr),
    .i_wdata  (bus.wr_data),
    .i_rd_en  (w_rd_en),
    .i_rd_clr (w_rd_clr),
    .i_rd_addr(w_rd_addr),
    .o_rd_data(w_rd_data)
  );

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_state     <= IDLE;
      r_len       <= '0;
      r_loop      <= 1'b0;
      r_step_idx  <= '0;
      r_vec_valid <= 1'b0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_wr_err    <= 1'b0;
      r_obs_count <= '0;
    end else begin
      r_done   <= 1'b0;
      r_wr_err <= bus.wr_en & (r_state == RUN);
      unique case (r_state)
        IDLE: begin
          if (w_start) begin
            r_len       <= w_len_clamped;
            r_loop      <= bus.loop_mode;
            r_obs_count <= '0;
            r_step_idx  <= '0;
            if (bus.run_len == '0) begin
              r_state <= FINISH;
              r_done  <= 1'b1;
            end else begin
              r_state     <= RUN;
              r_vec_valid <= 1'b1;
              r_busy      <= 1'b1;
            end
          end
        end
        RUN: begin
          // counted even on a stop cycle: the consumer took the word
          if (w_accept && w_rd_data[OBS_BIT] && (r_obs_count != '1))
            r_obs_count <= r_obs_count + CNT_ONE;
          if (bus.stop) begin
            r_state     <= IDLE;
            r_vec_valid <= 1'b0;
            r_busy      <= 1'b0;
            r_step_idx  <= '0;
          end else if (w_accept) begin
            if (w_last && !r_loop) begin
              r_state     <= FINISH;
              r_done      <= 1'b1;
              r_vec_valid <= 1'b0;
              r_busy      <= 1'b0;
              r_step_idx  <= '0;
            end else begin
              r_step_idx <= w_next_idx;
            end
          end
        end
        FINISH: r_state <= IDLE;
        default: r_state <= IDLE;
      endcase
    end
  end

  assign bus.vec_out   = w_rd_data;
  assign bus.vec_valid = r_vec_valid;
  assign bus.step_idx  = r_step_idx;
  assign bus.busy      = r_busy;
  assign bus.done      = r_done;
  assign bus.wr_err    = r_wr_err;
  assign bus.obs_count = r_obs_count;

endmodule

// File: tb/tb_stim_sequencer.sv
module tb_stim_sequencer;

  localparam int VEC_W  = 12;
  localparam int DEPTH  = 32;
  localparam int ADDR_W = 5;

  logic clock = 1'b0;
  logic reset;
  int   n_checks = 0;
  int   n_fail   = 0;

  always #5 clock = ~clock;

  stim_sequencer_if #(.VEC_W(VEC_W), .ADDR_W(ADDR_W), .CNT_W(16)) bus ();
  stim_sequencer_if #(.VEC_W(VEC_W), .ADDR_W(ADDR_W), .CNT_W(2))  bus_sat ();

  stim_sequencer #(
    .VEC_W(VEC_W), .DEPTH(DEPTH), .ADDR_W(ADDR_W), .OBS_BIT(VEC_W-1), .CNT_W(16)
  ) u_dut (
    .clock(clock),
    .reset(reset),
    .bus  (bus)
  );

  // narrow-counter copy, driven in lockstep, for the saturation check
  stim_sequencer #(
    .VEC_W(VEC_W), .DEPTH(DEPTH), .ADDR_W(ADDR_W), .OBS_BIT(VEC_W-1), .CNT_W(2)
  ) u_dut_sat (
    .clock(clock),
    .reset(reset),
    .bus  (bus_sat)
  );

  assign bus_sat.wr_en      = bus.wr_en;
  assign bus_sat.wr_addr    = bus.wr_addr;
  assign bus_sat.wr_data    = bus.wr_data;
  assign bus_sat.start      = bus.start;
  assign bus_sat.stop       = bus.stop;
  assign bus_sat.loop_mode  = bus.loop_mode;
  assign bus_sat.run_len    = bus.run_len;
  assign bus_sat.step_ready = bus.step_ready;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic wr(input int a, input int d);
    bus.wr_en   = 1'b1;
    bus.wr_addr = ADDR_W'(a);
    bus.wr_data = VEC_W'(d);
    tick();
    bus.wr_en   = 1'b0;
  endtask

  task automatic start_run(input int len, input logic lp);
    bus.run_len   = (ADDR_W+1)'(len);
    bus.loop_mode = lp;
    bus.start     = 1'b1;
    tick();
    bus.start     = 1'b0;
  endtask

  task automatic wait_done(input string tag);
    int i;
    i = 0;
    while (!bus.done && i < 200) begin
      tick();
      i++;
    end
    chk(tag, 32'(bus.done), 32'd1);
  endtask

  initial begin
    logic [VEC_W-1:0] t1 [4];
    int n_words;
    t1[0] = 12'h801; t1[1] = 12'h002; t1[2] = 12'h804; t1[3] = 12'h008;

    reset          = 1'b0;
    bus.wr_en      = 1'b0;
    bus.wr_addr    = '0;
    bus.wr_data    = '0;
    bus.start      = 1'b0;
    bus.stop       = 1'b0;
    bus.loop_mode  = 1'b0;
    bus.run_len    = '0;
    bus.step_ready = 1'b1;
    tick();
    tick();
    chk("rst_vec_out",   32'(bus.vec_out),   32'h0);
    chk("rst_vec_valid", 32'(bus.vec_valid), 32'h0);
    chk("rst_busy",      32'(bus.busy),      32'h0);
    chk("rst_done",      32'(bus.done),      32'h0);
    chk("rst_obs",       32'(bus.obs_count), 32'h0);
    reset = 1'b1;
    tick();

    // basic run, no stalls
    for (int i = 0; i < 4; i++) wr(i, int'(t1[i]));
    start_run(4, 1'b0);
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("t1_word%0d", i), 32'(bus.vec_out), 32'(t1[i]));
      chk($sformatf("t1_idx%0d", i),  32'(bus.step_idx), 32'(i));
      chk("t1_valid", 32'(bus.vec_valid), 32'd1);
      chk("t1_busy",  32'(bus.busy), 32'd1);
      tick();
    end
    chk("t1_done",    32'(bus.done), 32'd1);
    chk("t1_fin_vec", 32'(bus.vec_out), 32'h0);
    chk("t1_fin_vld", 32'(bus.vec_valid), 32'd0);
    chk("t1_obs",     32'(bus.obs_count), 32'd2);
    tick();
    chk("t1_done_pulse", 32'(bus.done), 32'd0);

    // back-pressure on entry 1
    start_run(4, 1'b0);
    chk("t2_obs_clr", 32'(bus.obs_count), 32'd0);
    chk("t2_w0", 32'(bus.vec_out), 32'h801);
    tick();
    chk("t2_w1", 32'(bus.vec_out), 32'h002);
    bus.step_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("t2_hold", 32'(bus.vec_out), 32'h002);
      chk("t2_hold_idx", 32'(bus.step_idx), 32'd1);
    end
    bus.step_ready = 1'b1;
    tick();
    chk("t2_w2", 32'(bus.vec_out), 32'h804);
    tick();
    chk("t2_w3", 32'(bus.vec_out), 32'h008);
    tick();
    chk("t2_done_c8", 32'(bus.done), 32'd1);
    chk("t2_obs", 32'(bus.obs_count), 32'd2);
    tick();

    // loop mode, 6 accepts, then stop
    wr(0, 12'h800);
    wr(1, 12'h001);
    start_run(2, 1'b1);
    for (int i = 0; i < 6; i++) begin
      chk($sformatf("t3_idx%0d", i), 32'(bus.step_idx), 32'(i % 2));
      chk("t3_no_done", 32'(bus.done), 32'd0);
      tick();
    end
    bus.step_ready = 1'b0;
    bus.stop       = 1'b1;
    tick();
    bus.stop       = 1'b0;
    bus.step_ready = 1'b1;
    chk("t3_stop_vec",  32'(bus.vec_out), 32'h0);
    chk("t3_stop_vld",  32'(bus.vec_valid), 32'd0);
    chk("t3_stop_busy", 32'(bus.busy), 32'd0);
    chk("t3_stop_done", 32'(bus.done), 32'd0);
    chk("t3_obs",       32'(bus.obs_count), 32'd3);
    tick();
    chk("t3_idle_vld",  32'(bus.vec_valid), 32'd0);

    // stop coinciding with the final accept: abort, accepted word still counted
    start_run(1, 1'b0);
    chk("t3b_word", 32'(bus.vec_out), 32'h800);
    bus.stop = 1'b1;
    tick();
    bus.stop = 1'b0;
    chk("t3b_done", 32'(bus.done), 32'd0);
    chk("t3b_busy", 32'(bus.busy), 32'd0);
    chk("t3b_obs",  32'(bus.obs_count), 32'd1);
    tick();
    chk("t3b_done_late", 32'(bus.done), 32'd0);

    // run_len = 0
    start_run(0, 1'b0);
    chk("t4_zero_done", 32'(bus.done), 32'd1);
    chk("t4_zero_vld",  32'(bus.vec_valid), 32'd0);
    chk("t4_zero_busy", 32'(bus.busy), 32'd0);
    tick();
    chk("t4_zero_done_end", 32'(bus.done), 32'd0);

    // run_len above DEPTH clamps
    start_run(40, 1'b0);
    n_words = 0;
    for (int i = 0; i < 100 && !bus.done; i++) begin
      if (bus.vec_valid) n_words++;
      tick();
    end
    chk("t4_clamp_done",  32'(bus.done), 32'd1);
    chk("t4_clamp_words", 32'(n_words), 32'd32);
    tick();

    // write during RUN is rejected
    for (int i = 0; i < 4; i++) wr(i, int'(t1[i]));
    start_run(4, 1'b0);
    bus.wr_en   = 1'b1;
    bus.wr_addr = '0;
    bus.wr_data = 12'hFFF;
    chk("t5_err_early", 32'(bus.wr_err), 32'd0);
    tick();
    bus.wr_en   = 1'b0;
    chk("t5_wr_err", 32'(bus.wr_err), 32'd1);
    tick();
    chk("t5_wr_err_pulse", 32'(bus.wr_err), 32'd0);
    wait_done("t5_done");
    tick();
    start_run(4, 1'b0);
    chk("t5_entry0_kept", 32'(bus.vec_out), 32'h801);
    bus.stop = 1'b1;
    tick();
    bus.stop = 1'b0;

    // start and stop together in IDLE
    bus.run_len   = 6'd4;
    bus.loop_mode = 1'b0;
    bus.start     = 1'b1;
    bus.stop      = 1'b1;
    tick();
    bus.start     = 1'b0;
    bus.stop      = 1'b0;
    chk("t5_ss_busy", 32'(bus.busy), 32'd0);
    chk("t5_ss_vld",  32'(bus.vec_valid), 32'd0);
    chk("t5_ss_done", 32'(bus.done), 32'd0);
    tick();
    chk("t5_ss_busy2", 32'(bus.busy), 32'd0);

    // async reset mid-run at step 2
    start_run(4, 1'b0);
    tick();
    tick();
    chk("t6_at_step2", 32'(bus.step_idx), 32'd2);
    #2 reset = 1'b0;
    #1;
    chk("t6_rst_vec",  32'(bus.vec_out), 32'h0);
    chk("t6_rst_vld",  32'(bus.vec_valid), 32'd0);
    chk("t6_rst_busy", 32'(bus.busy), 32'd0);
    chk("t6_rst_idx",  32'(bus.step_idx), 32'd0);
    #2 reset = 1'b1;
    tick();
    start_run(4, 1'b0);
    chk("t6_rerun_w0",  32'(bus.vec_out), 32'h801);
    chk("t6_rerun_idx", 32'(bus.step_idx), 32'd0);
    tick();
    chk("t6_rerun_w1",  32'(bus.vec_out), 32'h002);
    bus.stop = 1'b1;
    tick();
    bus.stop = 1'b0;

    // obs_count saturation with a 2-bit counter: 5 hits -> 3
    start_run(1, 1'b1);
    for (int i = 0; i < 5; i++) tick();
    bus.step_ready = 1'b0;
    bus.stop       = 1'b1;
    tick();
    bus.stop       = 1'b0;
    bus.step_ready = 1'b1;
    chk("t7_obs_wide", 32'(bus.obs_count), 32'd5);
    chk("t7_obs_sat",  32'(bus_sat.obs_count), 32'd3);
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, checks=%0d", n_checks);
    $fatal(1, "timeout");
  end

endmodule
